// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage and dmem_ctrl, plus the word-wide SRAM port.
// master = pipeline side (and SRAM read data); slave = the controller.
interface dmem_ctrl_if #(
    parameter int MEM_ADDR_WIDTH    = 10,
    parameter int MEMORY_MODE_WIDTH = 2
);
    // A request is taken when D_MEM_read|D_MEM_write is high while the controller is idle.
    // stall stays high until the access retires, and done pulses for exactly that one cycle.
    // The SRAM never back-pressures: sram_rdata is valid the cycle after a read strobe.
    logic                         D_MEM_read;
    logic                         D_MEM_write;
    logic [MEMORY_MODE_WIDTH-1:0] D_MEM_mode;
    logic                         D_MEM_unsigned;
    logic [31:0]                  addr;
    logic [31:0]                  wdata;
    logic [31:0]                  rdata;
    logic                         stall;
    logic                         done;
    logic                         sram_en;
    logic [3:0]                   sram_we;
    logic [MEM_ADDR_WIDTH-1:0]    sram_addr;
    logic [31:0]                  sram_wdata;
    logic [31:0]                  sram_rdata;

    modport master (
        output D_MEM_read, D_MEM_write, D_MEM_mode, D_MEM_unsigned, addr, wdata, sram_rdata,
        input  rdata, stall, done, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  D_MEM_read, D_MEM_write, D_MEM_mode, D_MEM_unsigned, addr, wdata, sram_rdata,
        output rdata, stall, done, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: splits word-crossing accesses into two SRAM beats,
// assembles loads with sign/zero extension and stalls the pipeline meanwhile.
module dmem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
    localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
    localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;
    localparam logic [MEM_ADDR_WIDTH-1:0] WA_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;

    // Latched request
    logic [2:0]                size_q;
    logic [1:0]                off_q;
    logic                      uns_q;
    logic                      wr_q;
    logic                      split_q;
    logic [MEM_ADDR_WIDTH-1:0] wa_q;
    logic [31:0]               lane_hi_q;
    logic [3:0]                mask_hi_q;
    logic [31:0]               buf_q;
    logic [31:0]               rdata_q;

    // Decode of the live request inputs
    logic                      req;
    logic [2:0]                req_size;
    logic [1:0]                req_off;
    logic                      req_split;
    logic [MEM_ADDR_WIDTH-1:0] req_wa;
    logic [63:0]               req_lane;
    logic [7:0]                req_mask;
    logic                      unused_addr_hi;

    // Load assembly
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] ld_pair;
    logic [31:0] ld_low;
    logic [31:0] ld_result;

    function automatic logic [2:0] size_of(input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            BYTE_MEMORY_MODE:     n = 3'd1;
            HALFWORD_MEMORY_MODE: n = 3'd2;
            WORD_MEMORY_MODE:     n = 3'd4;
            default:              n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] lane_of(input logic [31:0] d, input logic [2:0] n,
                                            input logic [1:0] o);
        logic [31:0] keep;
        case (n)
            3'd1:    keep = 32'h0000_00FF;
            3'd2:    keep = 32'h0000_FFFF;
            default: keep = 32'hFFFF_FFFF;
        endcase
        return {32'd0, d & keep} << {o, 3'b000};
    endfunction

    function automatic logic [7:0] mask_of(input logic [2:0] n, input logic [1:0] o);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return {4'd0, m} << o;
    endfunction

    assign req            = bus.D_MEM_read | bus.D_MEM_write;
    assign req_wa         = bus.addr[MEM_ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^bus.addr[31:MEM_ADDR_WIDTH+2];

    always_comb begin
        req_size  = size_of(bus.D_MEM_mode);
        req_off   = bus.addr[1:0];
        req_split = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
        req_lane  = lane_of(bus.wdata, req_size, req_off);
        req_mask  = mask_of(req_size, req_off);
    end

    // Only meaningful in DONE: for a split access word 0 sits in buf_q and the
    // second beat is arriving on sram_rdata; otherwise sram_rdata is word 0.
    always_comb begin
        w0      = split_q ? buf_q : bus.sram_rdata;
        w1      = split_q ? bus.sram_rdata : 32'd0;
        ld_pair = {w1, w0} >> {off_q, 3'b000};
        ld_low  = ld_pair[31:0];
        case (size_q)
            3'd1:    ld_result = uns_q ? {24'd0, ld_low[7:0]}  : {{24{ld_low[7]}}, ld_low[7:0]};
            3'd2:    ld_result = uns_q ? {16'd0, ld_low[15:0]} : {{16{ld_low[15]}}, ld_low[15:0]};
            default: ld_result = ld_low;
        endcase
    end

    assign bus.stall = !rst && ((state == IDLE && req) || state == FIRST || state == SECOND);
    assign bus.rdata = (state == DONE && !wr_q) ? ld_result : rdata_q;
    assign dbg_state = state;

    // SRAM strobes and done are registered: they are set up on the edge that
    // enters the state in which they must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            size_q         <= 3'd0;
            off_q          <= 2'd0;
            uns_q          <= 1'b0;
            wr_q           <= 1'b0;
            split_q        <= 1'b0;
            wa_q           <= '0;
            lane_hi_q      <= 32'd0;
            mask_hi_q      <= 4'd0;
            buf_q          <= 32'd0;
            rdata_q        <= 32'd0;
            bus.done       <= 1'b0;
            bus.sram_en    <= 1'b0;
            bus.sram_we    <= 4'd0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (req) begin
                        size_q         <= req_size;
                        off_q          <= req_off;
                        uns_q          <= bus.D_MEM_unsigned;
                        wr_q           <= bus.D_MEM_write;
                        split_q        <= req_split;
                        wa_q           <= req_wa;
                        lane_hi_q      <= req_lane[63:32];
                        mask_hi_q      <= req_mask[7:4];
                        bus.sram_en    <= 1'b1;
                        bus.sram_addr  <= req_wa;
                        bus.sram_we    <= bus.D_MEM_write ? req_mask[3:0] : 4'd0;
                        bus.sram_wdata <= bus.D_MEM_write ? req_lane[31:0] : 32'd0;
                        state          <= FIRST;
                    end
                end
                FIRST: begin
                    if (split_q) begin
                        bus.sram_en    <= 1'b1;
                        bus.sram_addr  <= wa_q + WA_ONE;
                        bus.sram_we    <= wr_q ? mask_hi_q : 4'd0;
                        bus.sram_wdata <= wr_q ? lane_hi_q : 32'd0;
                        state          <= SECOND;
                    end else begin
                        bus.sram_en    <= 1'b0;
                        bus.sram_we    <= 4'd0;
                        bus.sram_addr  <= '0;
                        bus.sram_wdata <= 32'd0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end
                end
                SECOND: begin
                    buf_q          <= bus.sram_rdata;
                    bus.sram_en    <= 1'b0;
                    bus.sram_we    <= 4'd0;
                    bus.sram_addr  <= '0;
                    bus.sram_wdata <= 32'd0;
                    bus.done       <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    if (!wr_q) begin
                        rdata_q <= ld_result;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus random bench for dmem_ctrl against a byte-addressed reference memory.
module tb_dmem_ctrl;
  localparam int AW = 10;
  localparam logic [1:0] MODE_B = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_W = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic [1:0] dbg_state;

  dmem_ctrl_if #(.MEM_ADDR_WIDTH(AW)) bus ();

  dmem_ctrl #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  // SRAM model
  logic [31:0] mem [0:(1<<AW)-1];

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
    end else if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= mem[bus.sram_addr];
    end
  end

  // scoreboard
  logic [7:0]  ref_mem [0:(4<<AW)-1];
  logic [31:0] exp_q[$];
  logic [31:0] last_load;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one complete access, checking strobes, stall, done timing and rdata
  task automatic access(input logic wr, input logic rd, input logic [1:0] mode,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    int n, o, done_cyc, done_at, nstrb;
    logic split;
    logic [AW-1:0] wa, wa1;
    logic [3:0] we_exp [2];
    logic [31:0] wd_exp [2];
    logic [31:0] v;
    logic [11:0] ba;
    n = (mode == MODE_B) ? 1 : (mode == MODE_H) ? 2 : 4;
    o = int'(a[1:0]);
    wa = a[AW+1:2];
    wa1 = wa + {{(AW-1){1'b0}}, 1'b1};
    split = (o + n) > 4;
    we_exp[0] = 4'd0; we_exp[1] = 4'd0;
    wd_exp[0] = 32'd0; wd_exp[1] = 32'd0;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      int bp;
      bp = o + i;
      ba = a[11:0] + 12'(i);
      if (wr) begin
        we_exp[bp/4][bp%4] = 1'b1;
        wd_exp[bp/4][8*(bp%4) +: 8] = wd[8*i +: 8];
        ref_mem[ba] = wd[8*i +: 8];
      end else begin
        v[8*i +: 8] = ref_mem[ba];
      end
    end
    if (!wr) begin
      if (n == 1) v[31:8] = uns ? 24'd0 : {24{v[7]}};
      if (n == 2) v[31:16] = uns ? 16'd0 : {16{v[15]}};
      exp_q.push_back(v);
      last_load = v;
    end

    @(negedge clk);
    bus.D_MEM_read = rd;
    bus.D_MEM_write = wr;
    bus.D_MEM_mode = mode;
    bus.D_MEM_unsigned = uns;
    bus.addr = a;
    bus.wdata = wd;
    #1;
    check("stall_at_request", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.D_MEM_read = 1'b0;
    bus.D_MEM_write = 1'b0;
    done_cyc = split ? 3 : 2;
    done_at = -1;
    nstrb = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (bus.sram_en) begin
        if (nstrb < 2) begin
          check($sformatf("strobe%0d_addr a=%h", nstrb, a), 32'(bus.sram_addr),
                32'(nstrb == 0 ? wa : wa1));
          check($sformatf("strobe%0d_we a=%h", nstrb, a), 32'(bus.sram_we), 32'(we_exp[nstrb]));
          if (wr) check($sformatf("strobe%0d_wdata a=%h", nstrb, a), bus.sram_wdata, wd_exp[nstrb]);
        end
        nstrb++;
      end
      check($sformatf("stall_c%0d a=%h", cyc, a), 32'(bus.stall), (cyc < done_cyc) ? 32'd1 : 32'd0);
      if (bus.done) begin
        done_at = cyc;
        if (!wr && exp_q.size() != 0) check($sformatf("load_rdata a=%h", a), bus.rdata, exp_q.pop_front());
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("done_cycle a=%h", a), 32'(done_at), 32'(done_cyc));
    check($sformatf("strobe_count a=%h", a), 32'(nstrb), split ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("stall_after_done", 32'(bus.stall), 32'd0);
    check("no_strobe_after_done", 32'(bus.sram_en), 32'd0);
    check("rdata_hold", bus.rdata, last_load);
  endtask

  initial begin
    logic [31:0] tmp0, tmp1;
    bus.D_MEM_read = 1'b0;
    bus.D_MEM_write = 1'b0;
    bus.D_MEM_mode = MODE_W;
    bus.D_MEM_unsigned = 1'b0;
    bus.addr = 32'd0;
    bus.wdata = 32'd0;
    last_load = 32'd0;
    for (int i = 0; i < (1 << AW); i++) begin
      tmp0 = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tmp0[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_sram_en", 32'(bus.sram_en), 32'd0);
    check("reset_sram_we", 32'(bus.sram_we), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    mem_init = 1'b0;

    // aligned word store then load
    access(1'b1, 1'b0, MODE_W, 1'b0, 32'h100, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, MODE_W, 1'b0, 32'h100, 32'd0);
    check("lw_const", bus.rdata, 32'hDEAD_BEEF);

    // byte loads
    access(1'b0, 1'b1, MODE_B, 1'b0, 32'h103, 32'd0);
    check("lb_const", bus.rdata, 32'hFFFF_FFDE);
    access(1'b0, 1'b1, MODE_B, 1'b1, 32'h103, 32'd0);
    check("lbu_const", bus.rdata, 32'h0000_00DE);

    // misaligned word store
    access(1'b1, 1'b0, MODE_W, 1'b0, 32'h102, 32'h1122_3344);

    // misaligned halfword load across words 0x40/0x41
    access(1'b1, 1'b0, MODE_B, 1'b0, 32'h103, 32'h0000_00AB);
    access(1'b1, 1'b0, MODE_B, 1'b0, 32'h104, 32'h0000_008C);
    access(1'b0, 1'b1, MODE_H, 1'b0, 32'h103, 32'd0);
    check("lh_split_const", bus.rdata, 32'hFFFF_8CAB);
    access(1'b0, 1'b1, MODE_H, 1'b1, 32'h103, 32'd0);
    check("lhu_split_const", bus.rdata, 32'h0000_8CAB);

    // reset while in SECOND of a split load
    @(negedge clk);
    bus.D_MEM_read = 1'b1;
    bus.D_MEM_mode = MODE_H;
    bus.D_MEM_unsigned = 1'b0;
    bus.addr = 32'h103;
    @(posedge clk); #1;
    bus.D_MEM_read = 1'b0;
    @(posedge clk); #1;
    check("rst_test_in_second", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort_stall", 32'(bus.stall), 32'd0);
    check("rst_abort_sram_en", 32'(bus.sram_en), 32'd0);
    check("rst_abort_rdata", bus.rdata, 32'd0);
    check("rst_abort_done", 32'(bus.done), 32'd0);
    check("rst_abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    check("rst_abort_no_late_done", 32'(bus.done), 32'd0);
    check("rst_abort_no_late_strobe", 32'(bus.sram_en), 32'd0);
    last_load = 32'd0;

    // word load wrapping from word 0x3FF to word 0x000
    access(1'b0, 1'b1, MODE_W, 1'b0, 32'hFFE, 32'd0);
    tmp0 = init_word(0);
    tmp1 = init_word((1 << AW) - 1);
    check("wrap_const", bus.rdata, {tmp0[15:0], tmp1[31:16]});

    // read and write together performs the write
    access(1'b1, 1'b1, MODE_W, 1'b0, 32'h200, 32'hCAFE_F00D);
    access(1'b0, 1'b1, MODE_W, 1'b0, 32'h200, 32'd0);
    check("rw_together_const", bus.rdata, 32'hCAFE_F00D);

    // random accesses, upper address bits included
    for (int k = 0; k < 40; k++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      access(w, w ? 1'($urandom_range(0, 1)) : 1'b1, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
